m_pc_branch: RTL and testbench

- Program-counter and branch-resolution stage, directly downstream of the 8-way OR reduction in the CPU datapath.
- Consumes the 16-bit ALU result and forms the zero flag from two `m_or8way` instances, one per byte. Forms the negative flag, evaluates the C-instruction jump field, and registers the next PC.
- Supplies `o_pc` to instruction ROM fetch.
- Adds a small boot/run/halt control FSM so the core can be stalled and single-stepped on the FPGA.

---
 rtl/m_pc_branch.sv | 132 +++++++++++++
 tb/tb_m_pc_branch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_pc_branch.sv
// Program-counter and branch-resolution stage with a boot/run/halt control FSM.
// Zero flag is built from two byte-wide OR reductions; all outputs are registered.

module m_or8way (
  input  logic [7:0] data,
  output logic       any
);
  assign any = |data;
endmodule

module m_pc_branch #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = 16'h0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_soft_rst,
  input  logic             i_en,
  input  logic             i_halt,
  input  logic             i_resume,
  input  logic             i_is_c,
  input  logic [2:0]       i_jmp,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic [WIDTH-1:0] i_a_reg,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_zr,
  output logic             o_ng,
  output logic             o_taken,
  output logic             o_run
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pc_r, pc_s;
  logic             zr_r, zr_s;
  logic             ng_r, ng_s;
  logic             taken_r, taken_s;
  logic             run_r;
  logic             lo_any_s, hi_any_s;
  logic             zr_c_s, ng_c_s, take_c_s;

  m_or8way u_or_lo (.data(i_alu_out[7:0]),  .any(lo_any_s));
  m_or8way u_or_hi (.data(i_alu_out[15:8]), .any(hi_any_s));

  assign zr_c_s   = ~(lo_any_s | hi_any_s);
  assign ng_c_s   = i_alu_out[WIDTH-1];
  assign take_c_s = i_is_c & ((i_jmp[2] & ng_c_s) | (i_jmp[1] & zr_c_s) |
                              (i_jmp[0] & ~ng_c_s & ~zr_c_s));

  // Next-state and next-output selection for the boot/run/halt controller.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    zr_s    = zr_r;
    ng_s    = ng_r;
    taken_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_s = ST_RUN;
        pc_s    = RESET_VEC;
        zr_s    = 1'b0;
        ng_s    = 1'b0;
      end
      ST_RUN: begin
        if (i_soft_rst) begin
          state_s = ST_BOOT;
          pc_s    = RESET_VEC;
          zr_s    = 1'b0;
          ng_s    = 1'b0;
        end else if (i_halt) begin
          state_s = ST_HALT;
        end else if (i_en) begin
          pc_s    = take_c_s ? i_a_reg : pc_r + WIDTH'(1);
          zr_s    = zr_c_s;
          ng_s    = ng_c_s;
          taken_s = take_c_s;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (i_soft_rst) begin
          state_s = ST_BOOT;
          pc_s    = RESET_VEC;
          zr_s    = 1'b0;
          ng_s    = 1'b0;
        end else if (i_resume) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_BOOT;
        pc_s    = RESET_VEC;
        zr_s    = 1'b0;
        ng_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; o_run reflects the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_VEC;
      zr_r    <= 1'b0;
      ng_r    <= 1'b0;
      taken_r <= 1'b0;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      zr_r    <= zr_s;
      ng_r    <= ng_s;
      taken_r <= taken_s;
      run_r   <= (state_s == ST_RUN);
    end
  end

  assign o_pc    = pc_r;
  assign o_zr    = zr_r;
  assign o_ng    = ng_r;
  assign o_taken = taken_r;
  assign o_run   = run_r;

endmodule

// File: tb/tb_m_pc_branch.sv
// Self-checking bench for m_pc_branch: directed scenarios plus a randomized run
// compared against a signed-arithmetic reference model of the stage.

module tb_m_pc_branch;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_soft_rst, i_en, i_halt, i_resume, i_is_c;
  logic [2:0]  i_jmp;
  logic [15:0] i_alu_out, i_a_reg;
  logic [15:0] o_pc;
  logic        o_zr, o_ng, o_taken, o_run;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 = boot, 1 = run, 2 = halt
  int          m_mode;
  logic [15:0] m_pc;
  logic        m_zr, m_ng, m_taken;

  always #5 i_clk = ~i_clk;

  m_pc_branch #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_soft_rst(i_soft_rst), .i_en(i_en),
    .i_halt(i_halt), .i_resume(i_resume), .i_is_c(i_is_c), .i_jmp(i_jmp),
    .i_alu_out(i_alu_out), .i_a_reg(i_a_reg), .o_pc(o_pc), .o_zr(o_zr),
    .o_ng(o_ng), .o_taken(o_taken), .o_run(o_run)
  );

  task automatic model_reset();
    m_mode = 0; m_pc = 16'h0000; m_zr = 1'b0; m_ng = 1'b0; m_taken = 1'b0;
  endtask

  task automatic model_edge();
    int  sval;
    logic take;
    sval = int'(i_alu_out);
    if (sval >= 32768) sval = sval - 65536;
    take = i_is_c && ((i_jmp[2] && sval < 0) || (i_jmp[1] && sval == 0) ||
                      (i_jmp[0] && sval > 0));
    m_taken = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1; m_pc = 16'h0000; m_zr = 1'b0; m_ng = 1'b0;
    end else if (m_mode == 1) begin
      if (i_soft_rst) begin
        m_mode = 0; m_pc = 16'h0000; m_zr = 1'b0; m_ng = 1'b0;
      end else if (i_halt) begin
        m_mode = 2;
      end else if (i_en) begin
        m_pc    = take ? i_a_reg : 16'((int'(m_pc) + 1) % 65536);
        m_zr    = (sval == 0);
        m_ng    = (sval < 0);
        m_taken = take;
      end
    end else begin
      if (i_soft_rst) begin
        m_mode = 0; m_pc = 16'h0000; m_zr = 1'b0; m_ng = 1'b0;
      end else if (i_resume) begin
        m_mode = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_soft_rst = 1'b0; i_en = 1'b0; i_halt = 1'b0; i_resume = 1'b0;
    i_is_c = 1'b0; i_jmp = 3'b000; i_alu_out = 16'h0000; i_a_reg = 16'h0000;
  endtask

  task automatic jump_to(input logic [15:0] target);
    idle_inputs();
    i_en = 1'b1; i_is_c = 1'b1; i_jmp = 3'b111; i_a_reg = target; i_alu_out = 16'h0007;
    tick();
    checks++;
    if (o_pc !== target) begin
      errors++; $display("FAIL jump_to pc got %h want %h", o_pc, target);
    end
  endtask

  task automatic test_reset();
    logic [15:0] exp_pc [5];
    logic        exp_run [5];
    exp_pc  = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003};
    exp_run = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    idle_inputs();
    i_rst_n = 1'b0;
    i_en = 1'b1;
    #12;
    model_reset();
    checks++;
    if (o_pc !== 16'h0000 || o_zr !== 1'b0 || o_ng !== 1'b0 || o_taken !== 1'b0 || o_run !== 1'b0) begin
      errors++; $display("FAIL reset_state got pc=%h zr=%b ng=%b tk=%b run=%b want all 0",
                         o_pc, o_zr, o_ng, o_taken, o_run);
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++;
      if (o_pc !== exp_pc[k] || o_run !== exp_run[k] || o_pc !== m_pc) begin
        errors++; $display("FAIL boot_seq[%0d] got pc=%h run=%b want pc=%h run=%b",
                           k, o_pc, o_run, exp_pc[k], exp_run[k]);
      end
    end
  endtask

  task automatic test_jump();
    jump_to(16'h0010);
    i_jmp = 3'b010; i_alu_out = 16'h0000; i_a_reg = 16'h0123;
    tick();
    checks++;
    if (o_pc !== 16'h0123 || o_zr !== 1'b1 || o_taken !== 1'b1) begin
      errors++; $display("FAIL jeq_taken got pc=%h zr=%b tk=%b want 0123 1 1", o_pc, o_zr, o_taken);
    end
    i_is_c = 1'b0;
    tick();
    checks++;
    if (o_taken !== 1'b0 || o_pc !== 16'h0124) begin
      errors++; $display("FAIL taken_pulse got pc=%h tk=%b want 0124 0", o_pc, o_taken);
    end
  endtask

  task automatic test_flags();
    jump_to(16'h0020);
    i_alu_out = 16'h8000; i_jmp = 3'b001; i_a_reg = 16'h0500;
    tick();
    checks++;
    if (o_pc !== 16'h0021 || o_ng !== 1'b1 || o_zr !== 1'b0 || o_taken !== 1'b0) begin
      errors++; $display("FAIL jgt_neg got pc=%h ng=%b zr=%b tk=%b want 0021 1 0 0", o_pc, o_ng, o_zr, o_taken);
    end
    i_jmp = 3'b100;
    tick();
    checks++;
    if (o_pc !== 16'h0500 || o_taken !== 1'b1) begin
      errors++; $display("FAIL jlt_neg got pc=%h tk=%b want 0500 1", o_pc, o_taken);
    end
    i_alu_out = 16'h0100; i_jmp = 3'b001; i_a_reg = 16'h0777;
    tick();
    checks++;
    if (o_pc !== 16'h0777 || o_zr !== 1'b0 || o_ng !== 1'b0 || o_taken !== 1'b1) begin
      errors++; $display("FAIL upper_byte got pc=%h zr=%b ng=%b tk=%b want 0777 0 0 1", o_pc, o_zr, o_ng, o_taken);
    end
    i_jmp = 3'b000; i_alu_out = 16'h0000;
    tick();
    checks++;
    if (o_pc !== 16'h0778 || o_taken !== 1'b0 || o_zr !== 1'b1) begin
      errors++; $display("FAIL never_jump got pc=%h tk=%b zr=%b want 0778 0 1", o_pc, o_taken, o_zr);
    end
  endtask

  task automatic test_wrap();
    jump_to(16'hFFFF);
    i_is_c = 1'b0;
    tick();
    checks++;
    if (o_pc !== 16'h0000 || o_run !== 1'b1) begin
      errors++; $display("FAIL wrap got pc=%h run=%b want 0000 1", o_pc, o_run);
    end
  endtask

  task automatic test_en_low();
    jump_to(16'h0033);
    i_en = 1'b0; i_alu_out = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (o_pc !== 16'h0033 || o_taken !== 1'b0 || o_ng !== 1'b0) begin
        errors++; $display("FAIL en_low[%0d] got pc=%h tk=%b ng=%b want 0033 0 0", k, o_pc, o_taken, o_ng);
      end
    end
  endtask

  task automatic test_halt();
    jump_to(16'h0005);
    i_is_c = 1'b0; i_halt = 1'b1; i_en = 1'b1; i_resume = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) i_resume = 1'b0;
      tick();
      checks++;
      if (o_pc !== 16'h0005 || o_run !== 1'b0 || o_taken !== 1'b0) begin
        errors++; $display("FAIL halted[%0d] got pc=%h run=%b tk=%b want 0005 0 0", k, o_pc, o_run, o_taken);
      end
    end
    i_resume = 1'b1;
    tick();
    checks++;
    if (o_pc !== 16'h0005 || o_run !== 1'b1) begin
      errors++; $display("FAIL resume got pc=%h run=%b want 0005 1", o_pc, o_run);
    end
    i_halt = 1'b0; i_resume = 1'b0;
    tick();
    checks++;
    if (o_pc !== 16'h0006) begin
      errors++; $display("FAIL after_resume got pc=%h want 0006", o_pc);
    end
  endtask

  task automatic test_async_reset();
    jump_to(16'h0042);
    i_is_c = 1'b0;
    #3;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (o_pc !== 16'h0000 || o_run !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h run=%b want 0000 0", o_pc, o_run);
    end
    #2;
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_pc !== 16'h0000 || o_run !== 1'b1) begin
      errors++; $display("FAIL post_async got pc=%h run=%b want 0000 1", o_pc, o_run);
    end
  endtask

  task automatic test_soft_reset();
    jump_to(16'h0099);
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0; i_soft_rst = 1'b1;
    tick();
    checks++;
    if (o_pc !== 16'h0000 || o_run !== 1'b0 || o_zr !== 1'b0) begin
      errors++; $display("FAIL soft_halt got pc=%h run=%b zr=%b want 0000 0 0", o_pc, o_run, o_zr);
    end
    tick();
    checks++;
    if (o_pc !== 16'h0000 || o_run !== 1'b1) begin
      errors++; $display("FAIL soft_boot got pc=%h run=%b want 0000 1", o_pc, o_run);
    end
    i_soft_rst = 1'b0;
    jump_to(16'h0044);
    i_soft_rst = 1'b1;
    tick();
    checks++;
    if (o_pc !== 16'h0000 || o_run !== 1'b0) begin
      errors++; $display("FAIL soft_run got pc=%h run=%b want 0000 0", o_pc, o_run);
    end
    i_soft_rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] pick [4];
    pick = '{16'h0000, 16'h8000, 16'h0100, 16'hFFFF};
    for (int k = 0; k < 400; k++) begin
      i_en       = ($urandom_range(0, 3) != 0);
      i_halt     = ($urandom_range(0, 15) == 0);
      i_resume   = ($urandom_range(0, 3) == 0);
      i_soft_rst = ($urandom_range(0, 63) == 0);
      i_is_c     = $urandom_range(0, 1) == 1;
      i_jmp      = 3'($urandom_range(0, 7));
      i_alu_out  = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
      i_a_reg    = 16'($urandom);
      tick();
      checks++;
      if (o_pc !== m_pc || o_zr !== m_zr || o_ng !== m_ng || o_taken !== m_taken ||
          o_run !== (m_mode == 1)) begin
        errors++;
        $display("FAIL random[%0d] got pc=%h zr=%b ng=%b tk=%b run=%b want pc=%h zr=%b ng=%b tk=%b run=%b",
                 k, o_pc, o_zr, o_ng, o_taken, o_run, m_pc, m_zr, m_ng, m_taken, (m_mode == 1));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_jump();
    test_flags();
    test_wrap();
    test_en_low();
    test_halt();
    test_async_reset();
    test_soft_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
